logic_gates_bist_ctrl: RTL and testbench
========================================

Name: logic_gates_bist_ctrl

Overview:
Built-in self-test sequencer for the two-input logic_gates datapath. On a start request it drives all four (a,b) input combinations into the gate block in order 00, 01, 10, 11. It waits a programmable settle time for each vector, then samples the seven gate outputs and checks them against a golden truth table. It reports pass/fail plus per-vector and per-gate failure maps, and sits beside the gate instance as its only stimulus source in test mode.

Parameters:
SETTLE_CYCLES, 2, idle cycles between driving a vector and sampling it (0..15 legal; 0 = sample on the cycle after drive).
GATE_MASK, 7'h7F, per-gate compare enable, same bit order as res_i; a 0 bit excludes that gate from checking.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  run request, sampled only in IDLE.
res_i  input  7  gate outputs {xnor_g, xor_g, nor_g, nand_g, not_g, or_g, and_g} (bit0 = and_g).
a_o  output  1  registered stimulus to gate input a.
b_o  output  1  registered stimulus to gate input b.
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle pulse at end of run.
pass  output  1  run result, valid from done, held until next accepted start.
fail_vec  output  4  bit v set if vector v={a,b} had any unmasked mismatch.
fail_gate  output  7  bit g set if gate g mismatched on any vector (masked bits always 0).

Behaviour:
- Clock/reset: one clock clk. rst_n is asynchronous and active-low. While rst_n=0 the block is in IDLE and a_o, b_o, busy, done, pass, fail_vec and fail_gate are all 0, immediately and independently of clk.
- States: IDLE, DRIVE, SETTLE, SAMPLE, DONE. 2-bit vector index vec; a_o=vec[1], b_o=vec[0].
- IDLE: if start=1 on an edge, go to DRIVE with vec=0 and clear pass, fail_vec and fail_gate. Otherwise stay. Previous results stay visible.
- DRIVE: a_o/b_o already hold vec, updated on the edge entering DRIVE. Next state is SETTLE if SETTLE_CYCLES>0, else SAMPLE. The settle counter loads 0.
- SETTLE: counter increments each cycle. Go to SAMPLE after exactly SETTLE_CYCLES cycles in SETTLE.
- SAMPLE: compute mism = (res_i ^ golden[vec]) & GATE_MASK. On the exit edge: fail_gate |= mism; fail_vec[vec] = |mism. If vec==3, go to DONE; else vec+1 and go to DRIVE.
- Golden table: vec0 = 7'b1011100, vec1 = 7'b0101110, vec2 = 7'b0101010, vec3 = 7'b1000011. not_g checks ~a.
- DONE: done=1 for exactly this one cycle. pass = (fail_vec==0), registered on the edge entering DONE so it is valid together with done. Next state is IDLE unconditionally.
- start is ignored while busy=1 (no queuing). start held high through DONE launches a new run from IDLE on the following edge.
- Latency: done is high after the 4*(SETTLE_CYCLES+2)-th rising edge following the edge that accepted start. This is 16 edges at the default.
- a_o/b_o hold their last value (1,1 after a full run) in DONE/IDLE until the next start. They are 0 only after reset.
- Reset mid-run aborts with no done pulse. All results read 0 afterwards.
- res_i is only sampled in SAMPLE. Values in other states are don't-care.

Test Plan:
1. Correct behavioural gate model, defaults, start pulse -> a_o/b_o step 00,01,10,11, each held 4 cycles. done on the 16th edge. pass=1, fail_vec=0, fail_gate=0, busy low the cycle after done.
2. xor_g stuck at 0 -> pass=0, fail_vec=4'b0110, fail_gate=7'b0100000. Repeat with GATE_MASK=7'h5F -> pass=1, fail_gate=0.
3. not_g wired as ~b instead of ~a -> fail_vec=4'b0110, fail_gate=7'b0000100, pass=0.
4. SETTLE_CYCLES=0 -> done on the 8th edge after start. Each vector is held 2 cycles, and res_i is sampled 1 cycle after drive.
5. start pulsed again while busy (vec=1) -> ignored, single done at the normal time. Then start held high continuously -> back-to-back runs with results cleared at each acceptance.
6. rst_n dropped asynchronously mid-cycle during vec=2 after a failing run -> all outputs 0 before the next edge, no done. After rst_n release, a start gives a full clean run with pass=1.

Source files
------------

// File: rtl/logic_gates_bist_ctrl.sv
// Built-in self-test sequencer for the two-input logic_gates block.
// Walks (a,b) through 00,01,10,11, waits SETTLE_CYCLES per vector, samples
// the seven gate outputs against a golden truth table and accumulates
// per-vector and per-gate failure maps plus an overall pass flag.
module logic_gates_bist_ctrl #(
  parameter int         SETTLE_CYCLES = 2,
  parameter logic [6:0] GATE_MASK     = 7'h7F
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [6:0] res_i,
  output logic       a_o,
  output logic       b_o,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_vec,
  output logic [6:0] fail_gate
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  // Last settle count value before moving to SAMPLE; unused when there is no settle phase.
  localparam logic [3:0] LP_SETTLE_LAST = 4'((SETTLE_CYCLES > 0) ? (SETTLE_CYCLES - 1) : 0);
  localparam bit         LP_HAS_SETTLE  = (SETTLE_CYCLES > 0);

  state_t     r_state;
  logic [1:0] r_vec;
  logic [3:0] r_cnt;
  logic       r_a;
  logic       r_b;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic [3:0] r_fail_vec;
  logic [6:0] r_fail_gate;

  logic [6:0] w_golden;
  logic [6:0] w_mism;
  logic [3:0] w_fail_vec_upd;
  logic [1:0] w_vec_inc;

  // Expected gate outputs {xnor,xor,nor,nand,not(a),or,and} for the current vector.
  always_comb begin
    w_golden = 7'b1011100;
    case (r_vec)
      2'd0:    w_golden = 7'b1011100;
      2'd1:    w_golden = 7'b0101110;
      2'd2:    w_golden = 7'b0101010;
      default: w_golden = 7'b1000011;
    endcase
  end

  assign w_mism    = (res_i ^ w_golden) & GATE_MASK;
  assign w_vec_inc = r_vec + 2'd1;

  // Per-vector failure map with the current vector's verdict merged in.
  always_comb begin
    w_fail_vec_upd        = r_fail_vec;
    w_fail_vec_upd[r_vec] = |w_mism;
  end

  // Sequencer: state, vector index, settle counter and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_vec       <= 2'd0;
      r_cnt       <= 4'd0;
      r_a         <= 1'b0;
      r_b         <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_fail_vec  <= 4'd0;
      r_fail_gate <= 7'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state     <= ST_DRIVE;
            r_vec       <= 2'd0;
            r_a         <= 1'b0;
            r_b         <= 1'b0;
            r_busy      <= 1'b1;
            r_pass      <= 1'b0;
            r_fail_vec  <= 4'd0;
            r_fail_gate <= 7'd0;
          end
        end
        ST_DRIVE: begin
          r_cnt   <= 4'd0;
          r_state <= LP_HAS_SETTLE ? ST_SETTLE : ST_SAMPLE;
        end
        ST_SETTLE: begin
          if (r_cnt == LP_SETTLE_LAST) begin
            r_state <= ST_SAMPLE;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        ST_SAMPLE: begin
          r_fail_gate <= r_fail_gate | w_mism;
          r_fail_vec  <= w_fail_vec_upd;
          if (r_vec == 2'd3) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
            r_pass  <= (w_fail_vec_upd == 4'd0);
          end else begin
            r_vec   <= w_vec_inc;
            r_a     <= w_vec_inc[1];
            r_b     <= w_vec_inc[0];
            r_state <= ST_DRIVE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign a_o       = r_a;
  assign b_o       = r_b;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign fail_vec  = r_fail_vec;
  assign fail_gate = r_fail_gate;

endmodule

// File: tb/tb_logic_gates_bist_ctrl.sv
// Testbench for logic_gates_bist_ctrl: two instances (default settle/mask and
// zero-settle with xor_g masked) driven by a behavioural gate block with
// injectable per-vector output corruption, checked every cycle against a
// run-timeline model, plus literal checks of latency and result maps.
module tb_logic_gates_bist_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;

  logic [1:0] a_w, b_w, busy_w, done_w, pass_w;
  logic [3:0] fv_w [2];
  logic [6:0] fg_w [2];
  logic [6:0] res_w [2];

  // Per-vector corruption applied to the true gate outputs (0 = healthy gates).
  logic [6:0] flip [4];

  int n_vec = 0;
  int n_err = 0;

  // Model state: t = cycles into the current run (0 = idle).
  int         P    [2] = '{4, 2};
  logic [6:0] MASK [2] = '{7'h7F, 7'h5F};
  int         t    [2] = '{0, 0};
  logic [1:0] e_a = '0, e_b = '0, e_done = '0, e_pass = '0;
  logic [3:0] e_fv [2] = '{4'd0, 4'd0};
  logic [6:0] e_fg [2] = '{7'd0, 7'd0};

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_gates
      assign res_w[gi] = {~(a_w[gi] ^ b_w[gi]), a_w[gi] ^ b_w[gi], ~(a_w[gi] | b_w[gi]),
                          ~(a_w[gi] & b_w[gi]), ~a_w[gi], a_w[gi] | b_w[gi], a_w[gi] & b_w[gi]}
                         ^ flip[{a_w[gi], b_w[gi]}];
    end
  endgenerate

  logic_gates_bist_ctrl u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .res_i(res_w[0]),
    .a_o(a_w[0]), .b_o(b_w[0]), .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
    .fail_vec(fv_w[0]), .fail_gate(fg_w[0])
  );

  logic_gates_bist_ctrl #(.SETTLE_CYCLES(0), .GATE_MASK(7'h5F)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .res_i(res_w[1]),
    .a_o(a_w[1]), .b_o(b_w[1]), .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
    .fail_vec(fv_w[1]), .fail_gate(fg_w[1])
  );

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s[dut%0d] got %0h expected %0h at %0t", nm, k, act, exp, $time);
    end
  endtask

  // Advance the model of instance k by one clock edge.
  task automatic step(input int k);
    int v;
    logic [6:0] m;
    if (t[k] == 0) begin
      if (start) begin
        t[k] = 1; e_a[k] = 1'b0; e_b[k] = 1'b0;
        e_fv[k] = 4'd0; e_fg[k] = 7'd0; e_pass[k] = 1'b0;
      end
    end else if (t[k] == 4 * P[k] + 1) begin
      t[k] = 0; e_done[k] = 1'b0;
    end else begin
      v = (t[k] - 1) / P[k];
      if ((t[k] - 1) % P[k] == P[k] - 1) begin
        m = flip[v] & MASK[k];
        e_fv[k][v] = |m;
        e_fg[k] = e_fg[k] | m;
      end
      t[k]++;
      if (t[k] == 4 * P[k] + 1) begin
        e_done[k] = 1'b1;
        e_pass[k] = (e_fv[k] == 4'd0);
      end else begin
        v = (t[k] - 1) / P[k];
        e_a[k] = v[1];
        e_b[k] = v[0];
      end
    end
  endtask

  always @(posedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 2; k++) step(k);
    end
  end

  always @(negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      t[k] = 0; e_fv[k] = 4'd0; e_fg[k] = 7'd0;
    end
    e_a = '0; e_b = '0; e_done = '0; e_pass = '0;
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk("a_o", k, 32'(a_w[k]), 32'(e_a[k]));
      chk("b_o", k, 32'(b_w[k]), 32'(e_b[k]));
      chk("busy", k, 32'(busy_w[k]), 32'(t[k] != 0));
      chk("done", k, 32'(done_w[k]), 32'(e_done[k]));
      chk("pass", k, 32'(pass_w[k]), 32'(e_pass[k]));
      chk("fail_vec", k, 32'(fv_w[k]), 32'(e_fv[k]));
      chk("fail_gate", k, 32'(fg_w[k]), 32'(e_fg[k]));
    end
  end

  // One run launched from idle; mode>0 pulses start at that edge count, mode<0 randomises start early in the run.
  task automatic run(input int mode, output int e0, output int e1);
    e0 = -1; e1 = -1;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (done_w[0] && e0 < 0) e0 = e;
      if (done_w[1] && e1 < 0) e1 = e;
      if (mode > 0)      start = (e == mode);
      else if (mode < 0) start = (e <= 6) ? 1'($urandom) : 1'b0;
      else               start = 1'b0;
    end
    start = 1'b0;
  endtask

  task automatic chk_results(input string nm, input int k, input logic p, input logic [3:0] fv, input logic [6:0] fg);
    chk({nm, "_pass"}, k, 32'(pass_w[k]), 32'(p));
    chk({nm, "_fvec"}, k, 32'(fv_w[k]), 32'(fv));
    chk({nm, "_fgate"}, k, 32'(fg_w[k]), 32'(fg));
  endtask

  task automatic set_flip(input logic [6:0] f0, input logic [6:0] f1, input logic [6:0] f2, input logic [6:0] f3);
    flip[0] = f0; flip[1] = f1; flip[2] = f2; flip[3] = f3;
  endtask

  int e0, e1, ndone;

  initial begin
    set_flip(7'd0, 7'd0, 7'd0, 7'd0);
    @(negedge clk);
    for (int k = 0; k < 2; k++) chk_results("rst", k, 1'b0, 4'd0, 7'd0);
    chk("rst_busy", 0, 32'(busy_w), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Healthy gates: clean pass, latency 16 / 8 edges.
    run(0, e0, e1);
    chk("lat_default", 0, 32'(e0), 32'd16);
    chk("lat_settle0", 1, 32'(e1), 32'd8);
    for (int k = 0; k < 2; k++) chk_results("clean", k, 1'b1, 4'd0, 7'd0);

    // xor_g stuck at 0: only vectors 01 and 10 expect xor=1.
    set_flip(7'd0, 7'b0100000, 7'b0100000, 7'd0);
    run(0, e0, e1);
    chk_results("xor_sa0", 0, 1'b0, 4'b0110, 7'b0100000);
    chk_results("xor_sa0_masked", 1, 1'b1, 4'b0000, 7'b0000000);

    // not_g driven from b: differs from ~a whenever a != b.
    set_flip(7'd0, 7'b0000100, 7'b0000100, 7'd0);
    run(0, e0, e1);
    for (int k = 0; k < 2; k++) chk_results("not_b", k, 1'b0, 4'b0110, 7'b0000100);

    // Start pulse while busy is ignored.
    set_flip(7'd0, 7'b0100000, 7'b0100000, 7'd0);
    run(4, e0, e1);
    chk("lat_glitch", 0, 32'(e0), 32'd16);

    // Start held high: back-to-back runs, three completions for the default instance.
    ndone = 0;
    start = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done_w[0]) ndone++;
      if (i == 53) start = 1'b0;
    end
    chk("b2b_done_count", 0, 32'(ndone), 32'd3);
    repeat (4) @(negedge clk);

    // Failing run, then asynchronous reset during vector 2.
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk_results("async_rst", k, 1'b0, 4'd0, 7'd0);
      chk("async_rst_ab", k, 32'({a_w[k], b_w[k]}), 32'd0);
      chk("async_rst_busy", k, 32'(busy_w[k]), 32'd0);
      chk("async_rst_done", k, 32'(done_w[k]), 32'd0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    set_flip(7'd0, 7'd0, 7'd0, 7'd0);
    run(0, e0, e1);
    chk("lat_after_rst", 0, 32'(e0), 32'd16);
    for (int k = 0; k < 2; k++) chk_results("after_rst", k, 1'b1, 4'd0, 7'd0);

    // Randomised corruption with stray start activity early in each run.
    for (int it = 0; it < 40; it++) begin
      for (int v = 0; v < 4; v++)
        flip[v] = ($urandom_range(0, 2) == 0) ? 7'd0 : 7'(1 << $urandom_range(0, 6)) | ((it % 5 == 0) ? 7'($urandom) : 7'd0);
      run(-1, e0, e1);
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
